decoder_3to8: RTL and testbench
===============================

Name: decoder_3to8

Overview:
Registered binary-to-one-hot decoder. Default configuration maps a 3-bit code to an 8-bit one-hot word.
- Used wherever a small select code drives per-line enables, e.g. register-bank write strobes or chip selects.
- Output is registered on the single clock with a synchronous active-high reset, giving a clean, glitch-free one-hot bus.

Parameters:
- IN_W, 3, width of the binary input code; legal range 1..6.
- OUT_W, 2**IN_W (8), width of the one-hot output; derived, not overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  decode enable; sampled each clock.
- in  input  IN_W  binary select code.
- out  output  OUT_W  registered one-hot result; bit[k] set when the captured code is k.
- valid  output  1  registered; high when out holds a decoded code.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All state updates on the rising edge of clk only; no asynchronous paths to outputs.
- Reset: rst=1 at an edge forces out=0 and valid=0. rst has priority over en.
- Decode, rst=0 and en=1 at an edge:
  - out <= (1 << in), exactly one bit set.
  - valid <= 1.
- Idle, rst=0 and en=0 at an edge: out <= 0, valid <= 0. The output does not hold the previous code.
- Latency: exactly 1 cycle from sampled in/en to out/valid. Back-to-back codes are accepted every cycle at full throughput.
- Every in value 0..OUT_W-1 is legal, so there is no out-of-range case.
- X/Z on in while en=1: implementation-defined. The bench must not drive it.
- Invariant: valid=1 implies popcount(out)==1; valid=0 implies out==0.
- Reset asserted mid-stream clears out and valid at the next edge. The first decode after reset deasserts appears one cycle after the first edge with en=1.
- Combinational core is a pure function of in. No state other than the out and valid registers.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- Defined:
  - out is presented active-low: the selected bit is 0 and all others are 1.
  - Reset and idle value of out is all ones.
  - valid is unchanged (active-high).
- Undefined: active-high one-hot as described above; reset and idle value of out is all zeros.

Decomposition:
- Shared package decoder_pkg holds:
  - the default DEC_IN_W = 3;
  - a function that computes the output width (2**w);
  - a function onehot(code) returning the one-hot vector, reusable by benches as the reference model.
- Natural sub-module: onehot_core, a purely combinational IN_W -> OUT_W decode.
- decoder_3to8 wraps onehot_core with the en/rst register stage and the optional inversion.

Test Plan:
- Reset: hold rst=1 for 3 cycles with en=1, in=5 -> out=8'h00 and valid=0 every cycle (8'hFF with DECODER_ACTIVE_LOW_EN).
- Sweep: en=1, in=0,1,...,7 on consecutive cycles -> one cycle later out=8'h01,02,04,08,10,20,40,80 in order, valid=1 throughout.
- Enable gating: en=1 with in=3, then en=0 with in=6 -> out=8'h08, valid=1, then out=8'h00, valid=0.
- Reset priority mid-stream: en=1 with in=7, rst pulsed high for one cycle -> that cycle out=0, valid=0; next decode with in=7 gives out=8'h80.
- Back-to-back changes: in alternating 2,5,2,5 with en=1 -> out alternates 8'h04, 8'h20 each cycle; popcount(out)==1 checked every valid cycle.
- Parameter check: IN_W=2, in=3 with en=1 -> out=4'b1000 after 1 cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered one-hot decoder.
// Consumers: onehot_core, decoder_3to8, and any bench wanting a reference decode.
package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_MAX_W = 6;

  function automatic int out_width(input int w);
    return 1 << w;
  endfunction

  // Reference decode at the widest legal size; callers slice what they need.
  function automatic logic [(1<<DEC_MAX_W)-1:0] onehot(input logic [DEC_MAX_W-1:0] code);
    logic [(1<<DEC_MAX_W)-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_core.sv
// Purely combinational binary-to-one-hot decode, IN_W -> 2**IN_W.
module onehot_core
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = out_width(IN_W)
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] dec
);

  // One comparator per output line keeps every bit independent of the others.
  for (genvar k = 0; k < OUT_W; k++) begin : g_line
    assign dec[k] = (code == IN_W'(k));
  end

endmodule

// File: rtl/decoder_3to8.sv
// Registered binary-to-one-hot decoder with synchronous active-high reset.
// Optional macro DECODER_ACTIVE_LOW_EN presents out active-low (idle all ones).
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = out_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  if (IN_W < 1 || IN_W > DEC_MAX_W) begin : g_bad_w
    $error("decoder_3to8: IN_W out of range 1..6");
  end
  if (OUT_W != out_width(IN_W)) begin : g_bad_ow
    $error("decoder_3to8: OUT_W must equal 2**IN_W");
  end

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] IDLE = '1;
`else
  localparam logic [OUT_W-1:0] IDLE = '0;
`endif

  logic [OUT_W-1:0] dec;

  onehot_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .code (in),
    .dec  (dec)
  );

  // XOR with the idle pattern applies the optional polarity inversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= IDLE;
      valid <= 1'b0;
    end else if (en) begin
      out   <= dec ^ IDLE;
      valid <= 1'b1;
    end else begin
      out   <= IDLE;
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Randomized self-checking bench for decoder_3to8 (default IN_W=3 plus an IN_W=2 instance).
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] in;
  logic [1:0] in2;
  logic [7:0] out;
  logic [3:0] out2;
  logic       valid, valid2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  decoder_3to8 dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out), .valid(valid)
  );

  decoder_3to8 #(.IN_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in2), .out(out2), .valid(valid2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: selected line value = 2**code; active-low just complements within width.
  function automatic logic [63:0] model(input bit r, input bit e, input int code, input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << (1 << w)) - 64'd1;
    v = (!r && e) ? (64'd1 << code) : 64'd0;
`ifdef DECODER_ACTIVE_LOW_EN
    v = ~v & mask;
`endif
    return v & mask;
  endfunction

  // Apply one cycle of stimulus, then check both instances 1 ns after the edge.
  task automatic step(input bit r, input bit e, input int code, input string tag);
    logic [7:0] o;
    rst = r; en = e; in = 3'(code); in2 = 2'(code);
    @(posedge clk);
    #1;
    chk({tag, ".out"},    64'(out),    model(r, e, code, 3));
    chk({tag, ".valid"},  64'(valid),  64'(!r && e));
    chk({tag, ".out2"},   64'(out2),   model(r, e, code % 4, 2));
    chk({tag, ".valid2"}, 64'(valid2), 64'(!r && e));
`ifdef DECODER_ACTIVE_LOW_EN
    o = ~out;
`else
    o = out;
`endif
    if (valid) chk({tag, ".pop"}, 64'($countones(o)), 64'd1);
    else       chk({tag, ".zero"}, 64'(o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in = 3'd5; in2 = 2'd1;

    for (int i = 0; i < 3; i++) step(1, 1, 5, "reset");

    for (int i = 0; i < 8; i++) step(0, 1, i, "sweep");

    step(0, 1, 3, "gate_on");
    step(0, 0, 6, "gate_off");

    step(0, 1, 7, "rstmid_pre");
    step(1, 1, 7, "rstmid");
    step(0, 1, 7, "rstmid_post");

    for (int i = 0; i < 4; i++) step(0, 1, (i % 2) ? 5 : 2, "alt");

    step(0, 1, 3, "w2_code3");

    for (int i = 0; i < 300; i++) begin
      bit r, e;
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, int'($urandom_range(0, 7)), "rand");
    end

    step(0, 0, 0, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
